stopwatch_timer: RTL and testbench

Parametrised BCD stopwatch/countdown timer, next generation of the team's single-digit-minute stopwatch. Adds an internal tick prescaler, a configurable minutes field width, preset load, lap capture and terminal-count handling for countdown mode (stop-at-zero or wrap). It sits between the board clock and the seven-segment display driver. It consumes debounced single-cycle button pulses and presents packed BCD digits.

---
 rtl/stopwatch_timer.sv | 212 +++++++++++++++++++++
 tb/tb_stopwatch_timer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer.sv
// -----------------------------------------------------------------------------
// stopwatch_timer
//
// BCD stopwatch / countdown timer with an internal tenth-second prescaler,
// preset load, lap capture and countdown terminal handling (halt or wrap).
// Sits between the board clock and the seven-segment display driver. All
// command inputs are debounced single-cycle pulses.
//
// Parameters:
//   TICK_DIV       clk cycles per tenth-second tick (>= 2)
//   MIN_DIGITS     number of BCD minute digits (1 or 2)
//   COUNTDOWN_STOP 1: countdown halts at zero and pulses done
//                  0: countdown wraps from zero to the maximum value
//
// Ports (W = 4*(MIN_DIGITS+3)):
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   start       in   pulse: begin / resume counting
//   stop        in   pulse: pause counting
//   clear       in   pulse: zero the time and stop
//   mode_down   in   1 = count down, 0 = count up (sampled on each tick)
//   load        in   pulse: preset time from load_value (clamped per digit)
//   load_value  in   packed BCD preset
//   lap         in   pulse: capture current time into lap_out
//   time_out    out  packed BCD time {minutes.., tens-s, ones-s, tenths}
//   lap_out     out  last captured time
//   lap_valid   out  one-cycle pulse when lap_out updates
//   running     out  counting enabled
//   done        out  one-cycle pulse when a countdown reaches zero
//   wrap        out  one-cycle pulse on any wrap-around
// -----------------------------------------------------------------------------
module stopwatch_timer #(
    parameter int TICK_DIV       = 10_000_000,
    parameter int MIN_DIGITS     = 1,
    parameter bit COUNTDOWN_STOP = 1'b1,
    localparam int NDIG          = MIN_DIGITS + 3,
    localparam int W             = 4 * NDIG
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         mode_down,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         lap,
    output logic [W-1:0] time_out,
    output logic [W-1:0] lap_out,
    output logic         lap_valid,
    output logic         running,
    output logic         done,
    output logic         wrap
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [W-1:0]  time_q,      time_d;
    logic [W-1:0]  lap_out_q,   lap_out_d;
    logic          lap_valid_q, lap_valid_d;
    logic          running_q,   running_d;
    logic          done_q,      done_d;
    logic          wrap_q,      wrap_d;
    logic [PW-1:0] presc_q,     presc_d;

    // -------------------------------------------------------------------------
    // Per-digit BCD arithmetic.
    // Digit 0 is tenths, 1 ones-seconds, 2 tens-seconds, 3.. minutes.
    // The carry/borrow chains start at 1 so inc_time/dec_time are always the
    // "ticked" value; a chain that ripples out of the top digit means the
    // result already wrapped (to zero going up, to MAX going down).
    // -------------------------------------------------------------------------
    logic [NDIG:0] carry;
    logic [NDIG:0] borrow;
    logic [W-1:0]  inc_time;
    logic [W-1:0]  dec_time;
    logic [W-1:0]  clamp_value;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            // Tens-of-seconds rolls over at 5, every other digit at 9.
            localparam logic [3:0] LIM = (gi == 2) ? 4'd5 : 4'd9;

            logic [3:0] cur;
            logic [3:0] ld;
            logic       at_lim;
            logic       at_zero;

            assign cur     = time_q[4*gi +: 4];
            assign ld      = load_value[4*gi +: 4];
            assign at_lim  = (cur == LIM);
            assign at_zero = (cur == 4'd0);

            assign inc_time[4*gi +: 4] = carry[gi]
                                       ? (at_lim ? 4'd0 : cur + 4'd1)
                                       : cur;
            assign carry[gi+1]         = carry[gi] & at_lim;

            assign dec_time[4*gi +: 4] = borrow[gi]
                                       ? (at_zero ? LIM : cur - 4'd1)
                                       : cur;
            assign borrow[gi+1]        = borrow[gi] & at_zero;

            // Out-of-range preset digits saturate at the digit's maximum.
            assign clamp_value[4*gi +: 4] = (ld > LIM) ? LIM : ld;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic tick;
    logic time_zero;
    logic start_blocked;
    logic dec_reaches_zero;

    assign tick             = running_q && (presc_q == PRESC_LAST);
    assign time_zero        = (time_q == '0);
    assign dec_reaches_zero = (dec_time == '0);
    // A countdown sitting at zero has nothing to count; refuse to start it.
    assign start_blocked    = COUNTDOWN_STOP && mode_down && time_zero;

    always_comb begin
        time_d      = time_q;
        presc_d     = presc_q;
        running_d   = running_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        // Lap always sees the value held before this cycle's update, so it
        // is independent of the command priority chain below.
        lap_out_d   = lap ? time_q : lap_out_q;
        lap_valid_d = lap;

        if (clear) begin
            time_d    = '0;
            running_d = 1'b0;
            presc_d   = '0;
        end else if (load) begin
            time_d  = clamp_value;
            presc_d = '0;
        end else if (stop) begin
            // Prescaler is held so a later resume keeps its phase; any tick
            // due this cycle is dropped.
            running_d = 1'b0;
        end else if (running_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (!mode_down) begin
                    time_d = inc_time;
                    wrap_d = carry[NDIG];
                end else if (borrow[NDIG]) begin
                    // Down tick while already at zero (reached by switching
                    // direction while running).
                    if (COUNTDOWN_STOP) begin
                        running_d = 1'b0;
                    end else begin
                        time_d = dec_time;
                        wrap_d = 1'b1;
                    end
                end else begin
                    time_d = dec_time;
                    if (COUNTDOWN_STOP && dec_reaches_zero) begin
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
        end else if (start && !start_blocked) begin
            // Prescaler is not touched: a fresh start runs from 0 (after
            // clear/reset/load), a resume continues from the held phase.
            running_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_q      <= '0;
            lap_out_q   <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            presc_q     <= '0;
        end else begin
            time_q      <= time_d;
            lap_out_q   <= lap_out_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            presc_q     <= presc_d;
        end
    end

    assign time_out  = time_q;
    assign lap_out   = lap_out_q;
    assign lap_valid = lap_valid_q;
    assign running   = running_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_timer
//
// Directed bench for stopwatch_timer with TICK_DIV=4, MIN_DIGITS=1. Two
// instances share all inputs: dut (countdown halts at zero) and dut_w
// (countdown wraps). Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_timer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stop, clear, mode_down, load, lap;
    logic [15:0] load_value;

    logic [15:0] time_out, lap_out;
    logic        lap_valid, running, done, wrap;
    logic [15:0] time_out_w, lap_out_w;
    logic        lap_valid_w, running_w, done_w, wrap_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(
        .TICK_DIV      (4),
        .MIN_DIGITS    (1),
        .COUNTDOWN_STOP(1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .mode_down (mode_down),
        .load      (load),
        .load_value(load_value),
        .lap       (lap),
        .time_out  (time_out),
        .lap_out   (lap_out),
        .lap_valid (lap_valid),
        .running   (running),
        .done      (done),
        .wrap      (wrap)
    );

    stopwatch_timer #(
        .TICK_DIV      (4),
        .MIN_DIGITS    (1),
        .COUNTDOWN_STOP(1'b0)
    ) dut_w (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .mode_down (mode_down),
        .load      (load),
        .load_value(load_value),
        .lap       (lap),
        .time_out  (time_out_w),
        .lap_out   (lap_out_w),
        .lap_valid (lap_valid_w),
        .running   (running_w),
        .done      (done_w),
        .wrap      (wrap_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Elapsed tenths -> packed BCD m:ss.t (single minute digit).
    function automatic logic [15:0] bcd(input int t);
        int m;
        int s;
        m = t / 600;
        s = (t / 10) % 60;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v; load = 1'b1; @(negedge clk); load = 1'b0;
    endtask

    initial begin
        int tw;
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
        mode_down  = 1'b0;
        load       = 1'b0;
        lap        = 1'b0;
        load_value = 16'h0000;

        // ---- reset state ----
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        check("rst_time",    32'(time_out), 32'h0);
        check("rst_lap",     32'(lap_out), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_pulses",  32'({lap_valid, done, wrap}), 32'h0);

        // ---- up count from zero, 40 cycles ----
        pulse_start();
        check("up_running", 32'(running), 32'h1);
        check("up_time_k0", 32'(time_out), 32'h0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("up_time_k%0d", k), 32'(time_out), 32'(bcd(k / 4)));
        end
        check("up_final", 32'(time_out), 32'h0010);

        // ---- up wrap at MAX ----
        pulse_clear();
        do_load(16'h9598);
        check("wrapup_load", 32'(time_out), 32'h9598);
        check("wrapup_stopped", 32'(running), 32'h0);
        pulse_start();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("wrapup_time_k%0d", k), 32'(time_out),
                  (k < 4) ? 32'h9598 : (k < 8) ? 32'h9599 : 32'h0000);
            check($sformatf("wrapup_wrap_k%0d", k), 32'(wrap), 32'(k == 8));
        end
        check("wrapup_running", 32'(running), 32'h1);

        // ---- countdown from 0:01.0 (halt vs wrap instance) ----
        pulse_clear();
        mode_down = 1'b1;
        do_load(16'h0010);
        pulse_start();
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            tw = 10 - k / 4;
            if (tw < 0) tw = 0;
            check($sformatf("down_time_k%0d", k), 32'(time_out), 32'(bcd(tw)));
            check($sformatf("down_done_k%0d", k), 32'(done), 32'(k == 40));
            check($sformatf("down_run_k%0d", k), 32'(running), 32'(k < 40));
            check($sformatf("downw_time_k%0d", k), 32'(time_out_w),
                  (k < 44) ? 32'(bcd(tw)) : 32'h9599);
            check($sformatf("downw_wrap_k%0d", k), 32'(wrap_w), 32'(k == 44));
        end
        check("downw_running", 32'(running_w), 32'h1);
        check("downw_no_done", 32'(done_w), 32'h0);
        // start at zero in countdown mode must be ignored
        pulse_start();
        check("down_start_ign_run", 32'(running), 32'h0);
        check("down_start_ign_done", 32'(done), 32'h0);
        cycles(5);
        check("down_start_ign_time", 32'(time_out), 32'h0);
        check("down_start_ign_run2", 32'(running), 32'h0);

        // ---- lap on a tick edge, stop/resume phase ----
        pulse_clear();
        mode_down = 1'b0;
        do_load(16'h0123);
        pulse_start();
        cycles(3);
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        check("lap_out", 32'(lap_out), 32'h0123);
        check("lap_valid", 32'(lap_valid), 32'h1);
        check("lap_time", 32'(time_out), 32'h0124);
        @(negedge clk);
        check("lap_valid_drop", 32'(lap_valid), 32'h0);
        pulse_stop();
        check("stop_running", 32'(running), 32'h0);
        cycles(10);
        check("stop_hold_time", 32'(time_out), 32'h0124);
        pulse_start();
        check("resume_k0", 32'(time_out), 32'h0124);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("resume_k%0d", k), 32'(time_out), (k < 3) ? 32'h0124 : 32'h0125);
        end

        // ---- clear + load + start + lap in one cycle ----
        clear = 1'b1; load = 1'b1; start = 1'b1; lap = 1'b1; load_value = 16'h0555;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; start = 1'b0; lap = 1'b0;
        check("combo_time", 32'(time_out), 32'h0);
        check("combo_running", 32'(running), 32'h0);
        check("combo_lap", 32'(lap_out), 32'h0125);
        check("combo_lap_valid", 32'(lap_valid), 32'h1);

        // ---- clamped load ----
        do_load(16'hFFFF);
        check("clamp_time", 32'(time_out), 32'h9599);
        check("clamp_running", 32'(running), 32'h0);

        // ---- asynchronous reset mid-count ----
        pulse_clear();
        pulse_start();
        cycles(9);
        lap = 1'b1; @(negedge clk); lap = 1'b0;
        check("pre_rst_time", 32'(time_out), 32'h0002);
        check("pre_rst_lap", 32'(lap_out), 32'h0002);
        #2 reset_n = 1'b0;
        #1;
        check("arst_time", 32'(time_out), 32'h0);
        check("arst_lap", 32'(lap_out), 32'h0);
        check("arst_running", 32'(running), 32'h0);
        check("arst_pulses", 32'({lap_valid, done, wrap}), 32'h0);
        check("arst_w_time", 32'(time_out_w), 32'h0);
        check("arst_w_lap", 32'(lap_out_w), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(6);
        check("post_rst_time", 32'(time_out), 32'h0);
        check("post_rst_running", 32'(running), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
